i2s_rx_bram_capture: RTL and testbench
======================================

Name: i2s_rx_bram_capture

Overview:
- Record-path counterpart of the BRAM-to-I2S playback DMA.
- Deserialises standard Philips I2S capture data from the codec ADC, which drives BCLK/LRCLK as master.
- Packs each stereo frame into one 32-bit word and writes it into a BRAM buffer of CLIP_LEN words. One-shot or loop mode.
- Sits between the codec record pins and the PS-visible BRAM, so software reads recorded clips.

Parameters:
- CLIP_LEN, 64: words (stereo frames) in the buffer; power of two, ≥2.
- SAMPLE_BITS, 16: captured bits per channel; 1..16. Extra slot bits are ignored.
- BASE_ADDR, 0: BRAM address of word 0.
- ADDR_INC, 1: BRAM address step per word.
- SYNC_STAGES, 2: synchroniser depth for I2S inputs; ≥2.

Ports:
- clk  in  1  system clock; must be ≥8× BCLK frequency.
- rst  in  1  reset, asynchronous, active-high.
- i2s_bclk  in  1  codec bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select; 0=left, 1=right.
- i2s_recdat  in  1  serial ADC data, MSB first.
- enable  in  1  level; capture runs while high.
- loop_mode  in  1  1 = wrap and continue; 0 = stop after CLIP_LEN words.
- BRAM_addr  out  32  write address.
- BRAM_clk  out  1  equals clk.
- BRAM_din  out  32  {right[15:0], left[15:0]}.
- BRAM_en  out  1  BRAM enable.
- BRAM_rst  out  1  BRAM reset.
- BRAM_we  out  4  byte write enables.
- wr_index  out  $clog2(CLIP_LEN)  index of next word to write.
- wrap  out  1  one-clk pulse when index wraps CLIP_LEN-1→0.
- done  out  1  one-shot capture complete; sticky until enable low or rst.

Behaviour:
- Reset (rst high, asynchronous): BRAM_addr=BASE_ADDR, BRAM_din=0, BRAM_en=0, BRAM_we=0, BRAM_rst=1, wr_index=0, wrap=0, done=0, state=IDLE. Deserialiser and synchronisers are cleared.
- BRAM_rst deasserts on the first clk after rst release.
- Input handling:
  - bclk, lrclk and recdat each pass through SYNC_STAGES flops.
  - A bclk rising edge is detected from the synchronised bclk (prev=0, cur=1). All sampling happens on that clk cycle.
- Deserialiser:
  - On each bclk rise, compare lrclk against its value at the previous bclk rise. A change marks the channel-transition edge and resets the bit counter to 0.
  - Bits on rises 1..SAMPLE_BITS after the transition edge shift MSB-first into that channel's register. Rise 0 carries the previous channel's LSB and is ignored. Rises beyond SAMPLE_BITS are ignored.
  - Samples are left-justified into 16 bits; unused LSBs are 0.
  - The bit counter saturates at SAMPLE_BITS.
  - frame_valid pulses for one clk on the rise that completes SAMPLE_BITS of the right channel, but only if a left word was completed since the last frame_valid.
- FSM:
  - IDLE: outputs quiet. enable=1 → SYNC.
  - SYNC: wait for the first lrclk 1→0 transition edge, discarding any partial frame → RUN.
  - RUN: on frame_valid → WRITE.
  - WRITE: exactly one clk with BRAM_en=1, BRAM_we=4'hF, BRAM_din={R,L}, BRAM_addr=BASE_ADDR+wr_index*ADDR_INC. This is the cycle after frame_valid.
  - Next cycle after WRITE: en=0, we=0, wr_index increments. If wr_index was CLIP_LEN-1:
    - it wraps to 0 and wrap pulses;
    - loop_mode=1 → RUN;
    - loop_mode=0 → DONE with done=1.
  - Otherwise → RUN.
  - DONE: hold. enable low → IDLE, done cleared, wr_index=0.
- enable deasserted:
  - In SYNC or RUN → IDLE at next clk. wr_index resets to 0.
  - In WRITE, the write completes first, then IDLE.
- loop_mode is sampled only at the WRITE of index CLIP_LEN-1.
- A frame_valid arriving in any state other than RUN is dropped. It cannot collide with WRITE because clk ≥8× BCLK.

Optional Feature:
- Macro I2S_RX_PEAK_METER_EN.
- Enabled: adds outputs peak_l and peak_r, each 16 bits.
  - Each holds the max absolute value of two's-complement samples written since the last wrap, done, or rst; -32768 counts as 32767.
  - Values are latched into peak_*_hold on wrap or done.
- Disabled: no ports or logic added.

Decomposition:
- Package audio_pkg holds CLIP_LEN, SAMPLE_BITS defaults, the capture state_t enum (IDLE, SYNC, RUN, WRITE, DONE) and the frame-word packing function.
- Sub-module i2s_rx_deser covers synchronisers, edge detection, shift registers and frame_valid.
- The top level holds the FSM and BRAM port.

Test Plan:
- Reset check: assert rst mid-WRITE → same cycle en=0, we=0, addr=BASE_ADDR, BRAM_rst=1; BRAM_rst=0 one clk after release.
- Single frame: enable=1, 32-bit slots, L=0x1234, R=0xABCD → one-cycle write, din=0xABCD1234, addr=BASE_ADDR, we=4'hF, wr_index 0→1.
- One-shot capture: loop_mode=0, 64 frames with L=n, R=~n → addrs 0..63 in order, done=1 after the 64th write, a 65th frame is not written.
- Loop mode: loop_mode=1, 70 frames → wrap pulses once after the write to addr 63, frame 65 overwrites addr 0.
- Framing: SAMPLE_BITS=16, 24-bit slots with MSBs 0x7FFF → stored 0x7FFF, trailing bits ignored. enable drops mid-right-word → no write, IDLE, wr_index=0.
- Peak meter (I2S_RX_PEAK_METER_EN): samples {-32768, 100, -5} on left → peak_l=32767 latched at wrap.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types, defaults and helpers for the I2S record path.
// The peak-meter helper abs_sat is used only when I2S_RX_PEAK_METER_EN is defined.
package audio_pkg;

    localparam int unsigned CLIP_LEN_DEF    = 64;
    localparam int unsigned SAMPLE_BITS_DEF = 16;
    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned WORD_W          = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        RUN   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] right;
        logic [SAMPLE_W-1:0] left;
    } frame_t;

    // Stereo frame as stored in BRAM: right channel in the upper half.
    function automatic logic [WORD_W-1:0] pack_frame(input logic [SAMPLE_W-1:0] left,
                                                     input logic [SAMPLE_W-1:0] right);
        frame_t f;
        f.right = right;
        f.left  = left;
        return f;
    endfunction

    // Magnitude of a two's-complement sample; the most negative value saturates.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
        if (s == 16'h8000) return 16'h7FFF;
        return s[SAMPLE_W-1] ? (~s + 16'd1) : s;
    endfunction

endpackage

// File: rtl/i2s_rx_deser.sv
// I2S slave deserialiser: synchronises codec clocks/data into clk, detects BCLK rises,
// shifts left/right samples MSB-first and flags each completed stereo frame.
module i2s_rx_deser
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i2s_bclk_i,
    input  logic                i2s_lrclk_i,
    input  logic                i2s_recdat_i,
    output logic [SAMPLE_W-1:0] left_o,
    output logic [SAMPLE_W-1:0] right_o,
    output logic                frame_valid_o,
    output logic                left_start_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_BITS + 1);

    logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, dat_sync_q;
    logic                   bclk_prev_q;
    logic                   lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]    left_q, left_d, right_q, right_d;
    logic                   left_done_q, left_done_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   left_start_q, left_start_d;

    logic bclk_s, lr_s, dat_s, bclk_rise;
    logic [3:0] bit_pos;

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s      = lr_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    // Left-justified placement: the n-th captured bit lands at bit 15-n.
    assign bit_pos   = 4'd15 - 4'(cnt_q);

    always_comb begin
        lr_prev_d     = lr_prev_q;
        cnt_d         = cnt_q;
        left_d        = left_q;
        right_d       = right_q;
        left_done_d   = left_done_q;
        frame_valid_d = 1'b0;
        left_start_d  = 1'b0;
        if (bclk_rise) begin
            lr_prev_d = lr_s;
            if (lr_s != lr_prev_q) begin
                // Transition rise carries the previous channel's LSB; start a new word.
                cnt_d = '0;
                if (lr_s) begin
                    right_d = '0;
                end else begin
                    left_d       = '0;
                    left_done_d  = 1'b0;
                    left_start_d = 1'b1;
                end
            end else if (cnt_q < CNT_W'(SAMPLE_BITS)) begin
                cnt_d = cnt_q + 1'b1;
                if (lr_s) right_d[bit_pos] = dat_s;
                else      left_d[bit_pos]  = dat_s;
                if (cnt_q == CNT_W'(SAMPLE_BITS - 1)) begin
                    if (!lr_s) begin
                        left_done_d = 1'b1;
                    end else if (left_done_q) begin
                        frame_valid_d = 1'b1;
                        left_done_d   = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_q   <= '0;
            lr_sync_q     <= '0;
            dat_sync_q    <= '0;
            bclk_prev_q   <= 1'b0;
            lr_prev_q     <= 1'b0;
            cnt_q         <= '0;
            left_q        <= '0;
            right_q       <= '0;
            left_done_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            left_start_q  <= 1'b0;
        end else begin
            bclk_sync_q   <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk_i};
            lr_sync_q     <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk_i};
            dat_sync_q    <= {dat_sync_q[SYNC_STAGES-2:0], i2s_recdat_i};
            bclk_prev_q   <= bclk_s;
            lr_prev_q     <= lr_prev_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            right_q       <= right_d;
            left_done_q   <= left_done_d;
            frame_valid_q <= frame_valid_d;
            left_start_q  <= left_start_d;
        end
    end

    assign left_o        = left_q;
    assign right_o       = right_q;
    assign frame_valid_o = frame_valid_q;
    assign left_start_o  = left_start_q;

endmodule

// File: rtl/i2s_rx_bram_capture.sv
// I2S record capture into a BRAM clip buffer (one-shot or looping).
// Define I2S_RX_PEAK_METER_EN to add per-channel peak_l/peak_r outputs latched at each wrap.
module i2s_rx_bram_capture
    import audio_pkg::*;
#(
    parameter int unsigned CLIP_LEN    = CLIP_LEN_DEF,
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] ADDR_INC    = 32'h1,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IDX_W      = $clog2(CLIP_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i2s_bclk,
    input  logic               i2s_lrclk,
    input  logic               i2s_recdat,
    input  logic               enable,
    input  logic               loop_mode,
    output logic [31:0]        BRAM_addr,
    output logic               BRAM_clk,
    output logic [31:0]        BRAM_din,
    output logic               BRAM_en,
    output logic               BRAM_rst,
    output logic [3:0]         BRAM_we,
    output logic [IDX_W-1:0]   wr_index,
    output logic               wrap,
    output logic               done
`ifdef I2S_RX_PEAK_METER_EN
    ,
    output logic [15:0]        peak_l,
    output logic [15:0]        peak_r
`endif
);

    logic [SAMPLE_W-1:0] left, right;
    logic                frame_valid, left_start;

    i2s_rx_deser #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk           (clk),
        .rst           (rst),
        .i2s_bclk_i    (i2s_bclk),
        .i2s_lrclk_i   (i2s_lrclk),
        .i2s_recdat_i  (i2s_recdat),
        .left_o        (left),
        .right_o       (right),
        .frame_valid_o (frame_valid),
        .left_start_o  (left_start)
    );

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d, din_q, din_d;
    logic               en_q, en_d, brst_q;
    logic [3:0]         we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d, done_q, done_d;
    logic               last_idx;

    assign last_idx = (idx_q == IDX_W'(CLIP_LEN - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                idx_d  = '0;
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (left_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (frame_valid) begin
                    state_d = WRITE;
                    en_d    = 1'b1;
                    we_d    = 4'hF;
                    din_d   = pack_frame(left, right);
                    addr_d  = BASE_ADDR + 32'(idx_q) * ADDR_INC;
                end
            end
            WRITE: begin
                // The write has been presented this cycle; advance and decide where to go.
                state_d = RUN;
                idx_d   = last_idx ? '0 : idx_q + 1'b1;
                if (last_idx) begin
                    wrap_d = 1'b1;
                    if (!loop_mode) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            din_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            brst_q  <= 1'b1;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            en_q    <= en_d;
            we_q    <= we_d;
            brst_q  <= 1'b0;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign BRAM_addr = addr_q;
    assign BRAM_clk  = clk;
    assign BRAM_din  = din_q;
    assign BRAM_en   = en_q;
    assign BRAM_rst  = brst_q;
    assign BRAM_we   = we_q;
    assign wr_index  = idx_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

`ifdef I2S_RX_PEAK_METER_EN
    logic [15:0] pk_l_q, pk_r_q, hold_l_q, hold_r_q;
    logic [15:0] abs_l, abs_r, pk_l_new, pk_r_new;

    // Running maxima include the word being written this cycle.
    assign abs_l    = abs_sat(din_q[15:0]);
    assign abs_r    = abs_sat(din_q[31:16]);
    assign pk_l_new = (abs_l > pk_l_q) ? abs_l : pk_l_q;
    assign pk_r_new = (abs_r > pk_r_q) ? abs_r : pk_r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_l_q   <= '0;
            pk_r_q   <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else if (state_q == WRITE) begin
            if (last_idx) begin
                hold_l_q <= pk_l_new;
                hold_r_q <= pk_r_new;
                pk_l_q   <= '0;
                pk_r_q   <= '0;
            end else begin
                pk_l_q <= pk_l_new;
                pk_r_q <= pk_r_new;
            end
        end
    end

    assign peak_l = hold_l_q;
    assign peak_r = hold_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx_bram_capture.sv
// Self-checking bench: drives Philips I2S frames as codec master and checks BRAM writes
// against expectations computed from the frame contents.
module tb_i2s_rx_bram_capture;

    localparam int unsigned CLIP      = 64;
    localparam logic [31:0] BASE      = 32'h0000_0100;
    localparam logic [31:0] INC       = 32'd4;
    localparam int unsigned HALF_BCLK = 40;
    localparam int unsigned SLOT      = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_recdat = 1'b0;
    logic        enable = 1'b0, loop_mode = 1'b0;
    logic [31:0] BRAM_addr, BRAM_din;
    logic        BRAM_clk, BRAM_en, BRAM_rst;
    logic [3:0]  BRAM_we;
    logic [5:0]  wr_index;
    logic        wrap, done;
`ifdef I2S_RX_PEAK_METER_EN
    logic [15:0] peak_l, peak_r;
`endif

    i2s_rx_bram_capture #(
        .CLIP_LEN    (CLIP),
        .SAMPLE_BITS (16),
        .BASE_ADDR   (BASE),
        .ADDR_INC    (INC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_recdat (i2s_recdat),
        .enable     (enable),
        .loop_mode  (loop_mode),
        .BRAM_addr  (BRAM_addr),
        .BRAM_clk   (BRAM_clk),
        .BRAM_din   (BRAM_din),
        .BRAM_en    (BRAM_en),
        .BRAM_rst   (BRAM_rst),
        .BRAM_we    (BRAM_we),
        .wr_index   (wr_index),
        .wrap       (wrap),
        .done       (done)
`ifdef I2S_RX_PEAK_METER_EN
        ,
        .peak_l     (peak_l),
        .peak_r     (peak_r)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Write monitor: every cycle with BRAM_en high is one recorded write.
    logic [31:0] mon_addr[$];
    logic [31:0] mon_din[$];
    logic [31:0] mon_we[$];
    int          wrap_cnt = 0;
    int          wrap_at  = -1;

    always @(negedge clk) begin
        if (BRAM_en === 1'b1) begin
            mon_addr.push_back(BRAM_addr);
            mon_din.push_back(BRAM_din);
            mon_we.push_back(32'(BRAM_we));
        end
        if (wrap === 1'b1) begin
            wrap_cnt = wrap_cnt + 1;
            wrap_at  = mon_addr.size();
        end
    end

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_mon();
        mon_addr.delete();
        mon_din.delete();
        mon_we.delete();
        wrap_cnt = 0;
        wrap_at  = -1;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Philips I2S: data lags the word select by one bit clock.
    logic prev_bit = 1'b0;

    task automatic send_bit(input logic lr, input logic b);
        i2s_lrclk  = lr;
        i2s_recdat = prev_bit;
        prev_bit   = b;
        #(HALF_BCLK) i2s_bclk = 1'b1;
        #(HALF_BCLK) i2s_bclk = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] bits, input int slot);
        for (int i = 0; i < slot; i++) send_bit(lr, bits[31-i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot);
        send_slot(1'b0, {l, 16'h0}, slot);
        send_slot(1'b1, {r, 16'h0}, slot);
    endtask

    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        checks++; if (BRAM_rst !== 1'b1) begin errors++; $display("FAIL reset_bram_rst: got %b expected 1", BRAM_rst); end
        checks++; if ({BRAM_en, BRAM_we} !== 5'b0) begin errors++; $display("FAIL reset_en_we: got %b expected 0", {BRAM_en, BRAM_we}); end
        checks++; if (BRAM_addr !== BASE) begin errors++; $display("FAIL reset_addr: got %h expected %h", BRAM_addr, BASE); end
        checks++; if (BRAM_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", BRAM_din); end
        checks++; if ({wr_index, wrap, done} !== 8'h0) begin errors++; $display("FAIL reset_idx_wrap_done: got %h expected 0", {wr_index, wrap, done}); end
        checks++; if (BRAM_clk !== clk) begin errors++; $display("FAIL bram_clk: got %b expected %b", BRAM_clk, clk); end
        rst = 1'b0;
        #1;
        checks++; if (BRAM_rst !== 1'b1) begin errors++; $display("FAIL bram_rst_hold: got %b expected 1", BRAM_rst); end
        @(negedge clk);
        checks++; if (BRAM_rst !== 1'b0) begin errors++; $display("FAIL bram_rst_release: got %b expected 0", BRAM_rst); end
    endtask

    task automatic test_single_frame();
        clear_mon();
        loop_mode = 1'b0;
        enable    = 1'b1;
        align();
        send_slot(1'b1, 32'h0, 32);
        send_frame(16'h1234, 16'hABCD, 32);
        wait_clks(4);
        checks++; if (mon_din.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", mon_din.size()); end
        checks++; if (qget(mon_din, 0) !== 32'hABCD1234) begin errors++; $display("FAIL single_din: got %h expected abcd1234", qget(mon_din, 0)); end
        checks++; if (qget(mon_addr, 0) !== BASE) begin errors++; $display("FAIL single_addr: got %h expected %h", qget(mon_addr, 0), BASE); end
        checks++; if (qget(mon_we, 0) !== 32'hF) begin errors++; $display("FAIL single_we: got %h expected f", qget(mon_we, 0)); end
        checks++; if (wr_index !== 6'd1) begin errors++; $display("FAIL single_index: got %0d expected 1", wr_index); end
        enable = 1'b0;
        wait_clks(3);
        checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL single_idle_index: got %0d expected 0", wr_index); end
    endtask

    task automatic test_one_shot();
        logic [15:0] lw;
        clear_mon();
        loop_mode = 1'b0;
        enable    = 1'b1;
        align();
        send_slot(1'b1, 32'h0, SLOT);
        for (int n = 0; n <= int'(CLIP); n++) begin
            lw = 16'(n);
            send_frame(lw, ~lw, SLOT);
            if (n == int'(CLIP) - 2) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done_early: got %b expected 0", done); end
            end
        end
        wait_clks(4);
        checks++; if (mon_din.size() != int'(CLIP)) begin errors++; $display("FAIL oneshot_count: got %0d expected %0d", mon_din.size(), CLIP); end
        for (int k = 0; k < int'(CLIP); k++) begin
            lw = 16'(k);
            checks++; if (qget(mon_addr, k) !== BASE + 32'(k) * INC) begin errors++; $display("FAIL oneshot_addr[%0d]: got %h expected %h", k, qget(mon_addr, k), BASE + 32'(k) * INC); end
            checks++; if (qget(mon_din, k) !== {~lw, lw}) begin errors++; $display("FAIL oneshot_din[%0d]: got %h expected %h", k, qget(mon_din, k), {~lw, lw}); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL oneshot_done: got %b expected 1", done); end
        checks++; if (wrap_cnt != 1 || wrap_at != int'(CLIP)) begin errors++; $display("FAIL oneshot_wrap: got count %0d at %0d expected 1 at %0d", wrap_cnt, wrap_at, CLIP); end
        checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL oneshot_index: got %0d expected 0", wr_index); end
        enable = 1'b0;
        wait_clks(3);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done_clear: got %b expected 0", done); end
    endtask

    task automatic test_loop();
        localparam int NF = 70;
        logic [15:0] l[NF];
        logic [15:0] r[NF];
        clear_mon();
        loop_mode = 1'b1;
        enable    = 1'b1;
        align();
        send_slot(1'b1, 32'h0, SLOT);
        for (int k = 0; k < NF; k++) begin
            l[k] = 16'($urandom);
            r[k] = 16'($urandom);
            send_frame(l[k], r[k], SLOT);
        end
        wait_clks(4);
        checks++; if (mon_din.size() != NF) begin errors++; $display("FAIL loop_count: got %0d expected %0d", mon_din.size(), NF); end
        for (int k = 0; k < NF; k++) begin
            checks++; if (qget(mon_addr, k) !== BASE + 32'(k % int'(CLIP)) * INC) begin errors++; $display("FAIL loop_addr[%0d]: got %h expected %h", k, qget(mon_addr, k), BASE + 32'(k % int'(CLIP)) * INC); end
            checks++; if (qget(mon_din, k) !== {r[k], l[k]}) begin errors++; $display("FAIL loop_din[%0d]: got %h expected %h", k, qget(mon_din, k), {r[k], l[k]}); end
        end
        checks++; if (wrap_cnt != 1 || wrap_at != int'(CLIP)) begin errors++; $display("FAIL loop_wrap: got count %0d at %0d expected 1 at %0d", wrap_cnt, wrap_at, CLIP); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done: got %b expected 0", done); end
        checks++; if (wr_index !== 6'(NF - int'(CLIP))) begin errors++; $display("FAIL loop_index: got %0d expected %0d", wr_index, NF - int'(CLIP)); end
        enable = 1'b0;
        wait_clks(3);
    endtask

    task automatic test_framing();
        logic [15:0] rv, l2;
        logic [31:0] rb;
        clear_mon();
        loop_mode = 1'b0;
        enable    = 1'b1;
        rv = 16'($urandom);
        l2 = 16'($urandom);
        align();
        send_slot(1'b1, 32'h0, 24);
        send_slot(1'b0, {16'h7FFF, 16'hFFFF}, 24);
        send_slot(1'b1, {rv, 16'hFFFF}, 24);
        wait_clks(4);
        checks++; if (qget(mon_din, 0) !== {rv, 16'h7FFF}) begin errors++; $display("FAIL framing_din: got %h expected %h", qget(mon_din, 0), {rv, 16'h7FFF}); end
        checks++; if (wr_index !== 6'd1) begin errors++; $display("FAIL framing_index: got %0d expected 1", wr_index); end
        // Drop enable part-way through the right word of the next frame.
        send_slot(1'b0, {l2, 16'h0}, 24);
        rb = {~l2, 16'h0};
        for (int i = 0; i < 24; i++) begin
            if (i == 8) enable = 1'b0;
            send_bit(1'b1, rb[31-i]);
        end
        wait_clks(4);
        checks++; if (mon_din.size() != 1) begin errors++; $display("FAIL framing_abort_count: got %0d expected 1", mon_din.size()); end
        checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL framing_abort_index: got %0d expected 0", wr_index); end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        clear_mon();
        loop_mode = 1'b0;
        enable    = 1'b1;
        align();
        send_slot(1'b1, 32'h0, SLOT);
        fork
            send_frame(16'h5A5A, 16'hC3C3, SLOT);
            begin
                cyc = 0;
                while (BRAM_en !== 1'b1 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
                checks++; if (BRAM_en !== 1'b1) begin errors++; $display("FAIL rstwr_timeout: got en=%b expected 1 within 2000 cycles", BRAM_en); end
                rst = 1'b1;
                #1;
                checks++; if ({BRAM_en, BRAM_we} !== 5'b0) begin errors++; $display("FAIL rstwr_en_we: got %b expected 0", {BRAM_en, BRAM_we}); end
                checks++; if (BRAM_addr !== BASE) begin errors++; $display("FAIL rstwr_addr: got %h expected %h", BRAM_addr, BASE); end
                checks++; if (BRAM_rst !== 1'b1) begin errors++; $display("FAIL rstwr_bram_rst: got %b expected 1", BRAM_rst); end
            end
        join
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (BRAM_rst !== 1'b0) begin errors++; $display("FAIL rstwr_release: got %b expected 0", BRAM_rst); end
        checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL rstwr_index: got %0d expected 0", wr_index); end
    endtask

`ifdef I2S_RX_PEAK_METER_EN
    task automatic test_peak();
        logic [15:0] l, r;
        int exp_l, exp_r, v;
        exp_l = 0;
        exp_r = 0;
        clear_mon();
        loop_mode = 1'b1;
        enable    = 1'b1;
        align();
        send_slot(1'b1, 32'h0, SLOT);
        for (int k = 0; k < int'(CLIP); k++) begin
            l = (k == 0) ? 16'h8000 : (k == 1) ? 16'd100 : (k == 2) ? 16'hFFFB : 16'h0;
            r = 16'($urandom_range(0, 2000)) - 16'd1000;
            v = int'($signed(l)); v = (v < 0) ? -v : v; if (v > 32767) v = 32767; if (v > exp_l) exp_l = v;
            v = int'($signed(r)); v = (v < 0) ? -v : v; if (v > 32767) v = 32767; if (v > exp_r) exp_r = v;
            send_frame(l, r, SLOT);
        end
        wait_clks(4);
        checks++; if (peak_l !== 16'(exp_l)) begin errors++; $display("FAIL peak_l: got %0d expected %0d", peak_l, exp_l); end
        checks++; if (peak_r !== 16'(exp_r)) begin errors++; $display("FAIL peak_r: got %0d expected %0d", peak_r, exp_r); end
        enable = 1'b0;
        wait_clks(3);
    endtask
`endif

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_one_shot();
        test_loop();
        test_framing();
        test_reset_mid_write();
`ifdef I2S_RX_PEAK_METER_EN
        test_peak();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
